// File: rtl/ddr3_pll_phase_sequencer.sv
// ddr3_pll_phase_sequencer: steps the DDR3 PLL dynamic phase-shift port one handshaked step at a time.
// Ports: CLK_IN/RST_IN clock and async active-high reset; PLL_LOCKED lock status (synchronized here);
//        req/req_updn/req_steps shift request; ack/busy/done/err request status;
//        position absolute phase modulo POS_MOD; phase_step/phase_updn/phase_done PLL handshake.
// Optional macro PHASE_SEQ_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on each phase_done edge wait.
module ddr3_pll_phase_sequencer #(
    parameter int STEP_HOLD   = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 6,
    parameter int POS_MOD     = 64,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                       CLK_IN,
    input  logic                       RST_IN,
    input  logic                       PLL_LOCKED,
    input  logic                       req,
    input  logic                       req_updn,
    input  logic [CNT_W-1:0]           req_steps,
    output logic                       ack,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(POS_MOD)-1:0] position,
    output logic                       phase_step,
    output logic                       phase_updn,
    input  logic                       phase_done
);
    localparam int PW = $clog2(POS_MOD);
    // One timer serves step hold, gap and watchdog; sized for the largest of them.
    localparam int TW = $clog2(TIMEOUT_CYC + STEP_HOLD + GAP_CYCLES + 1) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, STEP, WAIT_LO, WAIT_HI, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       lk_q, pd_q;
    logic             dir_q, dir_d, err_q, err_d, tmo;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [TW-1:0]    tmr_q, tmr_d;

    wire locked  = lk_q[1];
    wire pd_sync = pd_q[1];

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q <= IDLE;
            lk_q    <= '0;
            pd_q    <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            pos_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            lk_q    <= {lk_q[0], PLL_LOCKED};
            pd_q    <= {pd_q[0], phase_done};
            dir_q   <= dir_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        err_d   = err_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        ack     = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: if (req && locked) begin
                ack     = 1'b1;
                err_d   = 1'b0;
                dir_d   = req_updn;
                rem_d   = req_steps;
                state_d = (req_steps != '0) ? SETUP : DONE;
            end
            SETUP:   state_d = STEP;
            STEP:    if (tmr_q == TW'(STEP_HOLD - 1)) state_d = WAIT_LO;
            WAIT_LO: if (!pd_sync) state_d = WAIT_HI;
            WAIT_HI: if (pd_sync) begin
                state_d = GAP;
                rem_d   = rem_q - CNT_W'(1);
                pos_d   = dir_q ? ((pos_q == PW'(POS_MOD - 1)) ? '0 : pos_q + PW'(1))
                                : ((pos_q == '0) ? PW'(POS_MOD - 1) : pos_q - PW'(1));
            end
            GAP:     if (tmr_q == TW'(GAP_CYCLES - 1)) state_d = (rem_q != '0) ? SETUP : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef PHASE_SEQ_TIMEOUT_EN
        tmo = (state_q == WAIT_LO || state_q == WAIT_HI) && tmr_q == TW'(TIMEOUT_CYC - 1);
`endif
        if (tmo || (state_q != IDLE && !locked)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            pos_d   = pos_q;
        end
        // The PLL re-locks at its nominal phase, so an unlocked PLL means position 0.
        if (!locked) pos_d = '0;
        tmr_d = (state_d != state_q) ? '0 : tmr_q + TW'(1);
    end

    assign phase_step = state_q == STEP;
    assign phase_updn = state_q != IDLE && dir_q;
    assign busy       = ack || !(state_q == IDLE || state_q == DONE);
    assign done       = state_q == DONE && locked;
    assign err        = err_q;
    assign position   = pos_q;
endmodule

// File: tb/tb_ddr3_pll_phase_sequencer.sv
// tb_ddr3_pll_phase_sequencer: self-checking bench with a PLL handshake model and a result scoreboard.
module tb_ddr3_pll_phase_sequencer;
    localparam int CNT_W = 6;
    localparam int PW = 6;

    typedef struct {int pos; logic e; int steps;} exp_t;

    logic clk = 0, rst = 1, locked = 0, req = 0, req_updn = 0, phase_done = 1;
    logic [CNT_W-1:0] req_steps = '0;
    logic ack, busy, done, err, phase_step, phase_updn;
    logic [PW-1:0] position;

    int checks = 0, passed = 0;
    int cyc = 0, n_ack = 0, n_done = 0, n_steps = 0, bad_w = 0, bad_dir = 0, busy_cyc = 0;
    int ack_cyc = 0, done_cyc = 0, err_cyc = 0, pd_rise_cyc = 0, w = 0, pll_cnt = 0;
    logic exp_dir = 0, stuck = 0, ps_prev = 0, err_prev = 0, pll_prev = 0;
    logic [PW-1:0] pos_prev = '0;
    int pos_trace[$];
    exp_t sb[$];

    ddr3_pll_phase_sequencer #(.TIMEOUT_CYC(20)) dut (
        .CLK_IN(clk), .RST_IN(rst), .PLL_LOCKED(locked), .req(req), .req_updn(req_updn),
        .req_steps(req_steps), .ack(ack), .busy(busy), .done(done), .err(err),
        .position(position), .phase_step(phase_step), .phase_updn(phase_updn),
        .phase_done(phase_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // PLL: phase_done drops 3 cycles after a step starts and returns 4 cycles later.
    always @(negedge clk) begin
        if (phase_step && !pll_prev) pll_cnt = 1;
        else if (pll_cnt != 0) pll_cnt++;
        pll_prev = phase_step;
        if (pll_cnt == 3 && !stuck) phase_done = 0;
        if (pll_cnt == 7) begin
            if (!phase_done) pd_rise_cyc = cyc;
            phase_done = 1;
            pll_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (ack) begin n_ack++; ack_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; end
        if (busy) busy_cyc++;
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;
        if (phase_step) begin
            if (!ps_prev) begin n_steps++; w = 0; end
            w++;
            if (phase_updn !== exp_dir) bad_dir++;
        end else if (ps_prev && w != 2) bad_w++;
        ps_prev = phase_step;
        if (position !== pos_prev) pos_trace.push_back(int'(position));
        pos_prev = position;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic dir, input int steps, output logic ok);
        int a0 = n_ack;
        req_updn = dir;
        req_steps = CNT_W'(steps);
        exp_dir = dir;
        req = 1;
        for (int i = 0; i < 10 && n_ack == a0; i++) step_cyc();
        req = 0;
        ok = n_ack != a0;
    endtask

    task automatic wait_end(output logic ok);
        int d0 = n_done;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step_cyc();
            ok = n_done != d0 || err;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) step_cyc();
        checks++;
        if ({ack, busy, done, err, phase_step, phase_updn, position} !== '0)
            $display("FAIL reset_outputs: got %b want 0", {ack, busy, done, err, phase_step, phase_updn, position});
        else passed++;
        rst = 0;
        locked = 1;
        repeat (4) step_cyc();
        checks++;
        if ({busy, err, position} !== '0) $display("FAIL post_reset_idle: got %b want 0", {busy, err, position});
        else passed++;
    endtask

    task automatic test_up_five();
        exp_t e;
        logic ok;
        int a0 = n_ack, s0 = n_steps, d0 = n_done;
        sb.push_back('{5, 1'b0, 5});
        issue(1, 5, ok);
        wait_end(ok);
        e = sb.pop_front();
        checks++; if (!ok) $display("FAIL up5_complete: no done/err within budget"); else passed++;
        checks++; if (n_ack - a0 != 1) $display("FAIL up5_acks: got %0d want 1", n_ack - a0); else passed++;
        checks++; if (n_steps - s0 != e.steps) $display("FAIL up5_steps: got %0d want %0d", n_steps - s0, e.steps); else passed++;
        checks++; if (bad_w != 0) $display("FAIL up5_step_width: %0d pulses not 2 cycles wide", bad_w); else passed++;
        checks++; if (bad_dir != 0) $display("FAIL up5_updn: %0d step cycles with wrong phase_updn", bad_dir); else passed++;
        checks++; if (position !== PW'(e.pos)) $display("FAIL up5_position: got %0d want %0d", position, e.pos); else passed++;
        checks++; if (n_done - d0 != 1) $display("FAIL up5_done_count: got %0d want 1", n_done - d0); else passed++;
        checks++; if ({err, busy, phase_updn} !== {e.e, 2'b00}) $display("FAIL up5_final_flags: got %b want %b", {err, busy, phase_updn}, {e.e, 2'b00}); else passed++;
    endtask

    task automatic test_latency();
        exp_t e;
        logic ok;
        logic [3:0] exp_ps = 4'b0110;
        sb.push_back('{6, 1'b0, 1});
        issue(1, 1, ok);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (phase_step !== exp_ps[3-i]) $display("FAIL latency_step_T+%0d: got %b want %b", i + 1, phase_step, exp_ps[3-i]);
            else passed++;
            if (i < 3) step_cyc();
        end
        wait_end(ok);
        e = sb.pop_front();
        checks++; if (!ok || done_cyc - pd_rise_cyc != 5) $display("FAIL done_timing: got %0d want 5", done_cyc - pd_rise_cyc); else passed++;
        checks++; if (position !== PW'(e.pos)) $display("FAIL latency_position: got %0d want %0d", position, e.pos); else passed++;
    endtask

    task automatic test_down_wrap();
        exp_t e;
        logic ok;
        int d0;
        int want[3] = '{0, 63, 62};
        sb.push_back('{1, 1'b0, 5});
        issue(0, 5, ok);
        wait_end(ok);
        e = sb.pop_front();
        checks++; if (position !== PW'(e.pos)) $display("FAIL down_to_one: got %0d want %0d", position, e.pos); else passed++;
        sb.push_back('{62, 1'b0, 3});
        pos_trace.delete();
        d0 = n_done;
        issue(0, 3, ok);
        wait_end(ok);
        e = sb.pop_front();
        checks++; if (pos_trace.size() != 3) $display("FAIL wrap_trace_len: got %0d want 3", pos_trace.size()); else passed++;
        for (int i = 0; i < 3 && i < pos_trace.size(); i++) begin
            checks++;
            if (pos_trace[i] != want[i]) $display("FAIL wrap_trace[%0d]: got %0d want %0d", i, pos_trace[i], want[i]);
            else passed++;
        end
        checks++; if (position !== PW'(e.pos)) $display("FAIL wrap_position: got %0d want %0d", position, e.pos); else passed++;
        checks++; if (n_done - d0 != 1 || busy !== 1'b0) $display("FAIL wrap_done_busy: done %0d busy %b want 1 0", n_done - d0, busy); else passed++;
    endtask

    task automatic test_zero_steps();
        exp_t e;
        logic ok;
        int s0 = n_steps;
        sb.push_back('{62, 1'b0, 0});
        issue(1, 0, ok);
        wait_end(ok);
        e = sb.pop_front();
        checks++; if (!ok || done_cyc - ack_cyc != 1) $display("FAIL zero_done_latency: got %0d want 1", done_cyc - ack_cyc); else passed++;
        checks++; if (n_steps - s0 != e.steps) $display("FAIL zero_no_steps: got %0d want %0d", n_steps - s0, e.steps); else passed++;
        checks++; if (position !== PW'(e.pos)) $display("FAIL zero_position: got %0d want %0d", position, e.pos); else passed++;
    endtask

    task automatic test_lock_loss();
        exp_t e;
        logic ok;
        int s0 = n_steps, d0 = n_done;
        sb.push_back('{0, 1'b1, 2});
        issue(1, 4, ok);
        for (int i = 0; i < 100 && !(n_steps - s0 == 2 && phase_done == 0); i++) step_cyc();
        step_cyc();
        locked = 0;
        repeat (4) step_cyc();
        e = sb.pop_front();
        checks++; if (n_steps - s0 != e.steps) $display("FAIL lockloss_steps: got %0d want %0d", n_steps - s0, e.steps); else passed++;
        checks++; if ({phase_step, err, busy} !== {1'b0, e.e, 1'b0}) $display("FAIL lockloss_flags: got %b want %b", {phase_step, err, busy}, {1'b0, e.e, 1'b0}); else passed++;
        checks++; if (position !== PW'(e.pos)) $display("FAIL lockloss_position: got %0d want %0d", position, e.pos); else passed++;
        checks++; if (n_done != d0) $display("FAIL lockloss_no_done: got %0d done pulses want 0", n_done - d0); else passed++;
        locked = 1;
        repeat (4) step_cyc();
        checks++; if (err !== 1'b1) $display("FAIL lockloss_err_sticky: got %b want 1", err); else passed++;
        sb.push_back('{1, 1'b0, 1});
        issue(1, 1, ok);
        checks++; if (!ok || err !== 1'b0) $display("FAIL relock_accept_clears_err: ack %b err %b want 1 0", ok, err); else passed++;
        wait_end(ok);
        e = sb.pop_front();
        checks++; if (position !== PW'(e.pos)) $display("FAIL relock_position: got %0d want %0d", position, e.pos); else passed++;
    endtask

    task automatic test_held_req();
        exp_t e;
        logic ok;
        int a0 = n_ack, s0 = n_steps, b0;
        sb.push_back('{3, 1'b0, 2});
        req_updn = 1;
        req_steps = 2;
        exp_dir = 1;
        req = 1;
        for (int i = 0; i < 100 && n_steps - s0 < 2; i++) step_cyc();
        req = 0;
        wait_end(ok);
        e = sb.pop_front();
        checks++; if (n_ack - a0 != 1) $display("FAIL held_req_acks: got %0d want 1", n_ack - a0); else passed++;
        checks++; if (position !== PW'(e.pos)) $display("FAIL held_req_position: got %0d want %0d", position, e.pos); else passed++;
        locked = 0;
        repeat (4) step_cyc();
        a0 = n_ack;
        b0 = busy_cyc;
        req = 1;
        repeat (6) step_cyc();
        req = 0;
        checks++; if (n_ack != a0 || busy_cyc != b0) $display("FAIL unlocked_req: acks %0d busy cycles %0d want 0 0", n_ack - a0, busy_cyc - b0); else passed++;
        locked = 1;
        repeat (4) step_cyc();
    endtask

    task automatic test_timeout();
        exp_t e;
        logic ok;
        int d0 = n_done;
        stuck = 1;
        issue(1, 1, ok);
`ifdef PHASE_SEQ_TIMEOUT_EN
        sb.push_back('{3, 1'b1, 0});
        wait_end(ok);
        e = sb.pop_front();
        checks++; if (!ok || err_cyc - ack_cyc != 24) $display("FAIL timeout_latency: got %0d want 24", err_cyc - ack_cyc); else passed++;
        checks++; if ({err, busy} !== {e.e, 1'b0}) $display("FAIL timeout_flags: got %b want %b", {err, busy}, {e.e, 1'b0}); else passed++;
        checks++; if (position !== PW'(e.pos)) $display("FAIL timeout_position: got %0d want %0d", position, e.pos); else passed++;
`else
        sb.push_back('{0, 1'b1, 0});
        repeat (200) step_cyc();
        checks++; if ({busy, err} !== 2'b10) $display("FAIL hang_busy: got %b want 10", {busy, err}); else passed++;
        locked = 0;
        repeat (4) step_cyc();
        e = sb.pop_front();
        checks++; if ({err, busy} !== {e.e, 1'b0}) $display("FAIL hang_abort_flags: got %b want %b", {err, busy}, {e.e, 1'b0}); else passed++;
        checks++; if (position !== PW'(e.pos)) $display("FAIL hang_abort_position: got %0d want %0d", position, e.pos); else passed++;
`endif
        checks++; if (n_done != d0) $display("FAIL stall_no_done: got %0d want 0", n_done - d0); else passed++;
        stuck = 0;
        locked = 1;
        repeat (12) step_cyc();
    endtask

    task automatic test_async_reset();
        logic ok;
        checks++; if (bad_w != 0 || bad_dir != 0) $display("FAIL overall_step_shape: width errs %0d dir errs %0d want 0 0", bad_w, bad_dir); else passed++;
        issue(1, 3, ok);
        for (int i = 0; i < 20 && !phase_step; i++) step_cyc();
        #2 rst = 1;
        #1;
        checks++;
        if ({ack, busy, done, err, phase_step, phase_updn, position} !== '0)
            $display("FAIL async_reset_outputs: got %b want 0", {ack, busy, done, err, phase_step, phase_updn, position});
        else passed++;
        step_cyc();
        rst = 0;
        checks++; if (sb.size() != 0) $display("FAIL scoreboard_drained: got %0d entries want 0", sb.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_up_five();
        test_latency();
        test_down_wrap();
        test_zero_steps();
        test_lock_loss();
        test_held_req();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ddr3_pll_phase_sequencer.md
Name: ddr3_pll_phase_sequencer

Overview:
- Sequences the DDR3 PLL dynamic phase-shift port (phase_step / phase_updn / phase_done) on behalf of the write-leveling and read-calibration logic.
- Accepts "shift N steps up/down" requests and issues one PLL step at a time, each with a full phase_done handshake.
- Tracks the absolute phase position modulo one clock period and reports completion or error.
- Clocked by the same clock that drives the PLL phase_sclk input.

Parameters:
- STEP_HOLD, 2, cycles phase_step is held high per step (minimum 2).
- GAP_CYCLES, 2, idle cycles after each phase_done rise before the next step.
- CNT_W, 6, width of req_steps.
- POS_MOD, 64, phase steps per full 360-degree DDR3_CLK period; position wraps at this value.
- TIMEOUT_CYC, 1023, watchdog limit in cycles for each phase_done edge wait (used only with the optional feature).

Ports:
- CLK_IN  in  1  block clock; same net as PLL phase_sclk.
- RST_IN  in  1  asynchronous, active-high reset.
- PLL_LOCKED  in  1  PLL lock status; asynchronous, 2-flop synchronized internally.
- req  in  1  request; sampled only in IDLE.
- req_updn  in  1  1 = shift up (increment), 0 = shift down.
- req_steps  in  CNT_W  number of steps to shift.
- ack  out  1  one-cycle pulse when a request is accepted.
- busy  out  1  high from the accept cycle until done/err.
- done  out  1  one-cycle pulse when the request finishes.
- err  out  1  sticky error flag; cleared on the next accept.
- position  out  $clog2(POS_MOD)  current absolute phase position.
- phase_step  out  1  to PLL.
- phase_updn  out  1  to PLL.
- phase_done  in  1  from PLL; 2-flop synchronized internally.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; remaining-step counter 0.
  - Reset is asynchronous: outputs clear immediately, even mid-step.
- States and transitions:
  - IDLE: if req & locked_sync, latch req_updn and req_steps, pulse ack, set busy, clear err.
    - req_steps != 0 -> SETUP.
    - req_steps == 0 -> one-cycle DONE, no PLL activity.
  - SETUP: drive phase_updn = latched direction for 1 cycle, phase_step low -> STEP.
  - STEP: phase_step = 1 for exactly STEP_HOLD cycles -> WAIT_LO.
  - WAIT_LO: phase_step = 0; wait for synced phase_done == 0 -> WAIT_HI.
  - WAIT_HI: wait for synced phase_done == 1; on that cycle update position and decrement remaining -> GAP.
  - GAP: GAP_CYCLES idle cycles.
    - remaining != 0 -> SETUP.
    - remaining == 0 -> DONE.
  - DONE: pulse done, clear busy -> IDLE.
- phase_updn holds the latched direction from SETUP until IDLE is re-entered, then returns to 0.
- Position arithmetic:
  - Up: position + 1, with POS_MOD-1 wrapping to 0.
  - Down: position - 1, with 0 wrapping to POS_MOD-1.
  - Updated only on a completed step; never on request acceptance.
- Requests while busy are ignored (no ack). A requester must hold req until it sees ack.
- req while locked_sync == 0: not accepted; ack stays low and busy stays 0.
- Lock loss (locked_sync falls) in any non-IDLE state:
  - Next cycle: phase_step = 0, err = 1, busy = 0, position = 0 (the PLL re-locks at its nominal phase), state IDLE.
  - No done pulse.
- Lock loss while IDLE: position forced to 0; err unchanged.
- Latency for a 1-step request: ack at accept cycle T; phase_step high during T+2 .. T+1+STEP_HOLD.
- done timing: done fires GAP_CYCLES+1 cycles after the synchronized phase_done rise of the last step.

Optional Feature:
- Macro: PHASE_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_LO and WAIT_HI and reloads on each state entry.
  - Reaching TIMEOUT_CYC: abort exactly as for lock loss, except position is kept at its last completed value. err = 1, busy = 0, no done.
- Not defined: no counter; WAIT_LO/WAIT_HI wait indefinitely, and only lock loss or RST_IN exits them.

Test Plan:
- PLL model (phase_done low 3 cycles after step, high 4 cycles later); req up, req_steps=5 from position 0 -> one ack, exactly 5 phase_step pulses each 2 cycles wide, phase_updn=1 throughout, position=5, one done pulse, err=0.
- Position 1; req down, req_steps=3 -> position steps 0, 63, 62; done asserted; busy low afterwards.
- req_steps=0 -> ack, then done next cycle; phase_step never high; position unchanged.
- PLL_LOCKED dropped during WAIT_HI of step 2 of 4 -> phase_step low, err=1, busy=0, position=0, no done; next req with lock restored is accepted and clears err.
- With PHASE_SEQ_TIMEOUT_EN, TIMEOUT_CYC=20, phase_done stuck high -> err=1 about 20 cycles after entering WAIT_LO, position retained. Without the macro, busy stays high indefinitely.
- req held asserted while busy, plus req asserted while PLL_LOCKED=0 -> no extra ack in either case; exactly one ack per accepted request.
